// File: rtl/fft_bin_filter.sv
// Per-bin complex gain filter for streamed FFT frames with double-buffered coefficient banks.
// Build option: define FFT_FILTER_SAT_EN to saturate results to the signed DW range instead of wrapping.
module fft_bin_filter #(
  parameter int DW   = 16,
  parameter int N    = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [DW-1:0]        in_r,
  input  logic [DW-1:0]        in_i,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [CW-1:0]        coef_r,
  input  logic [CW-1:0]        coef_i,
  input  logic                 coef_commit,
  output logic                 out_valid,
  output logic [DW-1:0]        out_r,
  output logic [DW-1:0]        out_i,
  output logic [$clog2(N)-1:0] out_bin,
  output logic                 frame_done,
  output logic                 sof_err,
  output logic                 swap_pending
);

  localparam int AW = $clog2(N);
  localparam int PW = DW + CW;
  localparam int SW = DW + CW + 1;
  localparam int RW = SW + 1;
  localparam logic [CW-1:0]        UNITY = CW'(1) << FRAC;
  localparam logic signed [RW-1:0] HALF  = RW'(1) << (FRAC - 1);
`ifdef FFT_FILTER_SAT_EN
  localparam logic signed [RW-1:0] SMAX = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  // Round half-up at the FRAC point, then bring the result back to DW bits.
  function automatic logic [DW-1:0] round_reduce(input logic signed [SW-1:0] x);
    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;
    biased  = RW'(x) + HALF;
    shifted = biased >>> FRAC;
`ifdef FFT_FILTER_SAT_EN
    if (shifted > SMAX) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < SMIN) begin
      return {1'b1, {(DW-1){1'b0}}};
    end
`endif
    return DW'(shifted);
  endfunction

  logic                 act_q, act_d;
  logic                 pend_q, pend_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic signed [CW-1:0] bank_r_q [2][N];
  logic signed [CW-1:0] bank_i_q [2][N];
  logic signed [CW-1:0] bank_r_d [2][N];
  logic signed [CW-1:0] bank_i_d [2][N];

  logic [AW-1:0]        tag;
  logic                 swap;
  logic                 rd_sel;
  logic                 serr;
  logic signed [CW-1:0] rd_r, rd_i;

  logic                 vld_p0_q, vld_p0_d;
  logic                 serr_p0_q, serr_p0_d;
  logic [AW-1:0]        tag_p0_q, tag_p0_d;
  logic signed [DW-1:0] ar_p0_q, ar_p0_d;
  logic signed [DW-1:0] ai_p0_q, ai_p0_d;
  logic signed [CW-1:0] cr_p0_q, cr_p0_d;
  logic signed [CW-1:0] ci_p0_q, ci_p0_d;

  logic                 vld_p1_q, vld_p1_d;
  logic                 serr_p1_q, serr_p1_d;
  logic [AW-1:0]        tag_p1_q, tag_p1_d;
  logic signed [PW-1:0] rr_p1_q, rr_p1_d;
  logic signed [PW-1:0] ii_p1_q, ii_p1_d;
  logic signed [PW-1:0] ri_p1_q, ri_p1_d;
  logic signed [PW-1:0] ir_p1_q, ir_p1_d;

  logic signed [SW-1:0] re_full, im_full;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 sof_err_q, sof_err_d;
  logic [AW-1:0]        out_bin_q, out_bin_d;
  logic [DW-1:0]        out_r_q, out_r_d;
  logic [DW-1:0]        out_i_q, out_i_d;

  // Stage p0: bin tagging, bank control, coefficient read
  always_comb begin
    tag    = in_sof ? '0 : cnt_q;
    swap   = in_valid && (tag == '0) && (pend_q || coef_commit);
    rd_sel = swap ? ~act_q : act_q;
    serr   = in_valid && in_sof && (cnt_q != '0);
    cnt_d  = in_valid ? tag + AW'(1) : cnt_q;
    act_d  = act_q ^ swap;
    pend_d = swap ? 1'b0 : (pend_q | coef_commit);

    bank_r_d = bank_r_q;
    bank_i_d = bank_i_q;
    if (coef_we) begin
      bank_r_d[~act_q][coef_addr] = coef_r;
      bank_i_d[~act_q][coef_addr] = coef_i;
    end

    // A write landing in the bank being swapped in must be seen by this very sample.
    if (coef_we && swap && (coef_addr == tag)) begin
      rd_r = coef_r;
      rd_i = coef_i;
    end else begin
      rd_r = bank_r_q[rd_sel][tag];
      rd_i = bank_i_q[rd_sel][tag];
    end

    vld_p0_d  = in_valid;
    serr_p0_d = serr;
    tag_p0_d  = in_valid ? tag : tag_p0_q;
    ar_p0_d   = in_valid ? $signed(in_r) : ar_p0_q;
    ai_p0_d   = in_valid ? $signed(in_i) : ai_p0_q;
    cr_p0_d   = in_valid ? rd_r : cr_p0_q;
    ci_p0_d   = in_valid ? rd_i : ci_p0_q;
  end

  // Stage p1: four partial products
  always_comb begin
    vld_p1_d  = vld_p0_q;
    serr_p1_d = serr_p0_q;
    tag_p1_d  = vld_p0_q ? tag_p0_q : tag_p1_q;
    rr_p1_d   = vld_p0_q ? PW'(ar_p0_q) * PW'(cr_p0_q) : rr_p1_q;
    ii_p1_d   = vld_p0_q ? PW'(ai_p0_q) * PW'(ci_p0_q) : ii_p1_q;
    ri_p1_d   = vld_p0_q ? PW'(ar_p0_q) * PW'(ci_p0_q) : ri_p1_q;
    ir_p1_d   = vld_p0_q ? PW'(ai_p0_q) * PW'(cr_p0_q) : ir_p1_q;
  end

  // Stage p2: combine, round, reduce; data outputs hold while idle
  always_comb begin
    re_full      = SW'(rr_p1_q) - SW'(ii_p1_q);
    im_full      = SW'(ri_p1_q) + SW'(ir_p1_q);
    out_valid_d  = vld_p1_q;
    sof_err_d    = vld_p1_q && serr_p1_q;
    frame_done_d = vld_p1_q && (tag_p1_q == AW'(N - 1));
    out_bin_d    = vld_p1_q ? tag_p1_q : out_bin_q;
    out_r_d      = vld_p1_q ? round_reduce(re_full) : out_r_q;
    out_i_d      = vld_p1_q ? round_reduce(im_full) : out_i_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_q        <= 1'b0;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      vld_p0_q     <= 1'b0;
      serr_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      serr_p1_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      out_bin_q    <= '0;
      out_r_q      <= '0;
      out_i_q      <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank_r_q[b][k] <= UNITY;
          bank_i_q[b][k] <= '0;
        end
      end
    end else begin
      act_q        <= act_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      vld_p0_q     <= vld_p0_d;
      serr_p0_q    <= serr_p0_d;
      vld_p1_q     <= vld_p1_d;
      serr_p1_q    <= serr_p1_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      out_bin_q    <= out_bin_d;
      out_r_q      <= out_r_d;
      out_i_q      <= out_i_d;
      bank_r_q     <= bank_r_d;
      bank_i_q     <= bank_i_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_p0_q <= tag_p0_d;
    ar_p0_q  <= ar_p0_d;
    ai_p0_q  <= ai_p0_d;
    cr_p0_q  <= cr_p0_d;
    ci_p0_q  <= ci_p0_d;
    tag_p1_q <= tag_p1_d;
    rr_p1_q  <= rr_p1_d;
    ii_p1_q  <= ii_p1_d;
    ri_p1_q  <= ri_p1_d;
    ir_p1_q  <= ir_p1_d;
  end

  assign out_valid    = out_valid_q;
  assign out_r        = out_r_q;
  assign out_i        = out_i_q;
  assign out_bin      = out_bin_q;
  assign frame_done   = frame_done_q;
  assign sof_err      = sof_err_q;
  assign swap_pending = pend_q;

endmodule

// File: doc/fft_bin_filter.md
FFT_BIN_FILTER -- requirements
Module: fft_bin_filter

Interface
REQ-001 The block SHALL take parameter DW, default 16: signed sample width of the real and imaginary parts.
REQ-002 The block SHALL take parameter N, default 16: FFT frame length in bins; power of two, 4..1024.
REQ-003 The block SHALL take parameter CW, default 16: signed coefficient width of the real and imaginary parts.
REQ-004 The block SHALL take parameter FRAC, default 14: coefficient fraction bits; 1 <= FRAC < CW.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, named and sized as follows: clk in 1, rising-edge clock; reset_n in 1, async active-low reset.
REQ-006 The block SHALL have these data-path ports: in_valid in 1, sample strobe; in_sof in 1, marks bin 0 of a frame; in_r/in_i in DW, FFT bin sample.
REQ-007 The block SHALL have these coefficient ports: coef_we in 1, shadow write strobe; coef_addr in log2(N), bin index; coef_r/coef_i in CW, gain value; coef_commit in 1, request bank swap.
REQ-008 The block SHALL have these output ports: out_valid out 1; out_r/out_i out DW; out_bin out log2(N); frame_done out 1; sof_err out 1; swap_pending out 1.

Function
REQ-009 The block SHALL hold two coefficient banks of N complex entries each: one active bank (read) and one shadow bank (written).
REQ-010 coef_we SHALL write coef_r/coef_i into the shadow bank at coef_addr, visible at the next edge.
REQ-011 An accepted sample (in_valid=1) SHALL be tagged with the bin counter value; the counter then increments, wrapping N-1 -> 0.
REQ-012 in_sof=1 with in_valid=1 SHALL force the tag to 0 and set the counter to 1.
REQ-013 If the in_sof of REQ-012 arrives while the counter is nonzero, sof_err SHALL pulse for one cycle aligned with that sample's output.
REQ-014 coef_commit SHALL set swap_pending.
REQ-015 The banks SHALL swap when a sample tagged bin 0 is accepted while swap_pending=1, or while coef_commit=1 in the same cycle; that sample and the rest of its frame SHALL use the new bank, and swap_pending SHALL then clear.
REQ-016 If coef_we and the swap occur in the same cycle, the write SHALL land in the new active bank, i.e. the write is applied first.
REQ-017 The block SHALL compute out = in * coef as a complex product: re = ar*cr - ai*ci; im = ar*ci + ai*cr, at full precision (DW+CW+1 bits).
REQ-018 Each product part SHALL be rounded by adding 2^(FRAC-1), then arithmetic-shifting right by FRAC, then reduced to DW bits (REQ-027).
REQ-019 Latency SHALL be exactly 3 cycles: coefficient read/input register, multiply, add/round/reduce. Throughput SHALL be one sample per cycle, with no bubbles and no backpressure.
REQ-020 out_valid, out_bin and sof_err SHALL be pipelined alongside the data.
REQ-021 frame_done SHALL pulse together with the output tagged bin N-1.
REQ-022 When out_valid=0, out_r and out_i SHALL hold their last value.

Reset
REQ-023 reset_n low SHALL immediately clear out_valid, frame_done, sof_err, swap_pending, all pipeline valid bits, and the bin counter.
REQ-024 reset_n low SHALL set out_r, out_i and out_bin to 0.
REQ-025 reset_n low SHALL reset both banks to unity gain (2^FRAC, 0) and select bank 0 as active.
REQ-026 A reset mid-frame SHALL discard in-flight samples; no output for them SHALL appear after reset_n is released.

Configuration
REQ-027 With FFT_FILTER_SAT_EN defined, results outside the signed DW range SHALL clamp to +(2^(DW-1)-1) or -2^(DW-1); without it, results SHALL keep only their low DW bits (two's-complement wrap).

Verification
REQ-028 Unity gain after reset: sample 0x0100+j0x0200 at bin 3 -> 3 cycles later out_valid=1, out=0x0100+j0x0200, out_bin=3.
REQ-029 Commit behaviour: write bin 2 = (0, 0x4000) and commit mid-frame -> the current frame's bin 2 is unchanged; the next frame's bin-2 input 0x0100+j0 -> out 0x0000+j0x0100; swap_pending clears at that frame's bin 0.
REQ-030 Overflow: coef 0x7FFF+j0 with input 0x7000 -> out_r=0x7FFF with FFT_FILTER_SAT_EN, 0xDFFE without.
REQ-031 Negative rounding: coef 0x2000+j0 with input 0xFFF8+j0x0007 -> out 0xFFFC+j0x0004.
REQ-032 Framing: 16 back-to-back samples -> frame_done with out_bin=15; a mid-frame in_sof at counter 5 -> that output has out_bin=0 and sof_err=1.
REQ-033 Reset mid-operation: reset_n low with 3 samples in flight -> out_valid=0 at once and stays 0 after release; all coefficients read back as unity.
